// File: rtl/axis_insert_header_gen_if.sv
// Bundle of the three streams around the header inserter: the payload stream,
// the header side channel and the repacked output stream, plus the sticky
// keep error flag.
//   slave  : the inserter's view (payload/header sinks, output source)
//   master : the surrounding logic's view (payload/header source, output sink)
interface axis_insert_header_gen_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD:0]    byte_insert_cnt;
    logic                    ready_insert;

    logic                    err_keep;

    modport slave (
        input  valid_in, data_in, keep_in, last_in, ready_out,
               valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_in, valid_out, data_out, keep_out, last_out,
               ready_insert, err_keep
    );

    modport master (
        output valid_in, data_in, keep_in, last_in, ready_out,
               valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_in, valid_out, data_out, keep_out, last_out,
               ready_insert, err_keep
    );
endinterface

// File: rtl/axis_insert_header_gen.sv
// Prepends a 0..N byte header to each AXI-Stream packet and repacks the
// payload into full beats, adding a trailing beat when the carried bytes
// overflow the last input beat. Byte lane N-1 is first on the wire.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave view of axis_insert_header_gen_if (payload in,
//                header in, repacked stream out, sticky err_keep)
//
// state  | meaning
// IDLE   | waiting for a header; ready_insert high
// STREAM | passing payload beats, merging carried bytes into each beat
// FLUSH  | emitting the overflow bytes of the last payload beat
module axis_insert_header_gen #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input logic                     clk,
    input logic                     rst_n,
    axis_insert_header_gen_if.slave bus
);
    localparam int N  = DATA_BYTE_WD;
    localparam int CW = BYTE_CNT_WD + 1;
    localparam logic [CW-1:0] N_C = CW'(N);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t             state;
    logic [DATA_WD-1:0] carry;
    logic [CW-1:0]      hreg;
    logic [CW-1:0]      rem;
    logic               valid_out_r;
    logic [DATA_WD-1:0] data_out_r;
    logic [N-1:0]       keep_out_r;
    logic               last_out_r;
    logic               err_keep_r;

    // Mask with the top c byte lanes set (c in 0..N).
    function automatic logic [N-1:0] top_mask(input logic [CW-1:0] c);
        logic [N-1:0] ones;
        ones = '1;
        return ~(ones >> c);
    endfunction

    function automatic logic [DATA_WD-1:0] lane_mask(input logic [N-1:0] m);
        logic [DATA_WD-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*8 +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

    logic               out_free;
    logic [CW-1:0]      k;
    logic [CW-1:0]      h_clamp;
    logic [CW-1:0]      room;
    logic               fits;
    logic [CW-1:0]      last_cnt;
    logic [DATA_WD-1:0] stream_data;
    logic [DATA_WD-1:0] flush_data;
    logic               unused_keep_insert;

    assign out_free         = !valid_out_r || bus.ready_out;
    assign bus.ready_in     = (state == STREAM) && out_free;
    assign bus.ready_insert = (state == IDLE);

    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) begin
            k = k + CW'(bus.keep_in[i]);
        end
    end

    assign h_clamp  = (bus.byte_insert_cnt > N_C) ? N_C : bus.byte_insert_cnt;
    assign room     = N_C - hreg;
    assign fits     = (k <= room);
    // Only meaningful when fits, so it never exceeds N.
    assign last_cnt = hreg + k;

    // Window of {carry, data_in} starting at carry's byte hreg-1: the carried
    // bytes land in the MSB lanes followed by the top N-hreg payload bytes.
    assign stream_data = DATA_WD'({carry, bus.data_in} >> {hreg, 3'b000});
    assign flush_data  = carry << {room, 3'b000};

    assign unused_keep_insert = ^bus.keep_insert;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            carry       <= '0;
            hreg        <= '0;
            rem         <= '0;
            valid_out_r <= 1'b0;
            data_out_r  <= '0;
            keep_out_r  <= '0;
            last_out_r  <= 1'b0;
            err_keep_r  <= 1'b0;
        end else begin
            if (bus.ready_out) begin
                valid_out_r <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.valid_insert) begin
                        carry <= bus.data_insert;
                        hreg  <= h_clamp;
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (bus.valid_in && bus.ready_in) begin
                        carry       <= bus.data_in;
                        valid_out_r <= 1'b1;
                        if (bus.keep_in != top_mask(k)) begin
                            err_keep_r <= 1'b1;
                        end
                        if (bus.last_in && fits) begin
                            data_out_r <= stream_data & lane_mask(top_mask(last_cnt));
                            keep_out_r <= top_mask(last_cnt);
                            last_out_r <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            data_out_r <= stream_data;
                            keep_out_r <= '1;
                            last_out_r <= 1'b0;
                            if (bus.last_in) begin
                                rem   <= k - room;
                                state <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        valid_out_r <= 1'b1;
                        data_out_r  <= flush_data & lane_mask(top_mask(rem));
                        keep_out_r  <= top_mask(rem);
                        last_out_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.valid_out = valid_out_r;
    assign bus.data_out  = data_out_r;
    assign bus.keep_out  = keep_out_r;
    assign bus.last_out  = last_out_r;
    assign bus.err_keep  = err_keep_r;
endmodule

// File: tb/tb_axis_insert_header_gen.sv
// Self-checking bench for axis_insert_header_gen (N = 4). Expected output
// beats come from a byte-queue model: header bytes then payload bytes are
// concatenated and re-chunked into N-byte beats.
module tb_axis_insert_header_gen;
    localparam int DATA_WD = 32;
    localparam int N       = DATA_WD / 8;
    localparam int CW      = $clog2(N) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_insert_header_gen_if #(.DATA_WD(DATA_WD)) bus ();

    axis_insert_header_gen #(.DATA_WD(DATA_WD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DATA_WD-1:0] data;
        logic [N-1:0]       keep;
        logic               last;
    } beat_t;

    beat_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [DATA_WD-1:0] pay_data[16];
    logic [N-1:0]       pay_keep[16];
    int                 pay_k[16];
    int                 rdy_mode = 1;
    bit                 hold_ins = 0;

    function automatic logic [N-1:0] keep_top(input int k);
        logic [N-1:0] m;
        m = '0;
        for (int j = 0; j < k; j++) m[N-1-j] = 1'b1;
        return m;
    endfunction

    task automatic build_expected(input logic [DATA_WD-1:0] hdr, input int h, input int nb);
        byte unsigned bq[$];
        beat_t        bt;
        bit           null_beat;
        int           m;
        for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[i*8 +: 8]);
        for (int b = 0; b < nb; b++)
            for (int j = 0; j < pay_k[b]; j++) bq.push_back(pay_data[b][(N-1-j)*8 +: 8]);
        // No header and an empty last beat still produce a closing null beat.
        null_beat = (h == 0) && (pay_k[nb-1] == 0);
        while (bq.size() > 0) begin
            m = (bq.size() < N) ? bq.size() : N;
            bt.data = '0;
            for (int j = 0; j < m; j++) bt.data[(N-1-j)*8 +: 8] = bq.pop_front();
            bt.keep = keep_top(m);
            bt.last = (bq.size() == 0) && !null_beat;
            exp_q.push_back(bt);
        end
        if (null_beat) begin
            bt.data = '0;
            bt.keep = '0;
            bt.last = 1'b1;
            exp_q.push_back(bt);
        end
    endtask

    task automatic gen_payload(input int nb);
        for (int b = 0; b < nb; b++) begin
            pay_data[b] = $urandom;
            if (b < nb - 1) pay_k[b] = N;
            else if ($urandom_range(0, 9) == 0) pay_k[b] = 0;
            else pay_k[b] = $urandom_range(1, N);
            pay_keep[b] = keep_top(pay_k[b]);
        end
    endtask

    task automatic send_packet(input logic [DATA_WD-1:0] hdr, input int cnt, input int nb, input bit gaps);
        int           h;
        bit           hs;
        int           c;
        logic [N-1:0] ki;
        h = (cnt > N) ? N : cnt;
        build_expected(hdr, h, nb);
        ki = '0;
        for (int j = 0; j < h; j++) ki[j] = 1'b1;
        bus.data_insert     = hdr;
        bus.byte_insert_cnt = CW'(cnt);
        bus.keep_insert     = ki;
        bus.valid_insert    = 1'b1;
        hs = 0;
        c  = 0;
        while (!hs && c < 2000) begin
            @(negedge clk);
            hs = bus.ready_insert;
            @(posedge clk);
            #1;
            c++;
        end
        if (!hs) check_val("hdr_timeout", 64'(hs), 64'd1);
        if (!hold_ins) bus.valid_insert = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.valid_in = 1'b1;
            bus.data_in  = pay_data[b];
            bus.keep_in  = pay_keep[b];
            bus.last_in  = (b == nb - 1);
            hs = 0;
            c  = 0;
            while (!hs && c < 2000) begin
                @(negedge clk);
                hs = bus.ready_in;
                check_val("rdy_ins_busy", 64'(bus.ready_insert), 64'd0);
                @(posedge clk);
                #1;
                c++;
            end
            if (!hs) check_val("beat_timeout", 64'(hs), 64'd1);
        end
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 5000) begin
            @(posedge clk);
            c++;
        end
        #1;
        check_val("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // ready_out generator
    initial begin
        bus.ready_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.ready_out = 1'($urandom_range(0, 1));
                1:       bus.ready_out = 1'b1;
                2:       bus.ready_out = 1'b0;
                default: bus.ready_out = ~bus.ready_out;
            endcase
        end
    end

    // Output monitor: scoreboard compare on transfer, stability while stalled.
    initial begin
        bit    held;
        beat_t held_b;
        beat_t e;
        held = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
            end else begin
                if (held) begin
                    check_val("hold_valid", 64'(bus.valid_out), 64'd1);
                    check_val("hold_beat", {bus.data_out, bus.keep_out, bus.last_out},
                              {held_b.data, held_b.keep, held_b.last});
                end
                if (bus.valid_out && bus.ready_out) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_beat", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("data_out", 64'(bus.data_out), 64'(e.data));
                        check_val("keep_out", 64'(bus.keep_out), 64'(e.keep));
                        check_val("last_out", 64'(bus.last_out), 64'(e.last));
                    end
                end
                held        = bus.valid_out && !bus.ready_out;
                held_b.data = bus.data_out;
                held_b.keep = bus.keep_out;
                held_b.last = bus.last_out;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d beats pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid_in        = 1'b0;
        bus.data_in         = '0;
        bus.keep_in         = '0;
        bus.last_in         = 1'b0;
        bus.valid_insert    = 1'b0;
        bus.data_insert     = '0;
        bus.keep_insert     = '0;
        bus.byte_insert_cnt = '0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid_out", 64'(bus.valid_out), 64'd0);
        check_val("rst_last_out", 64'(bus.last_out), 64'd0);
        check_val("rst_data_out", 64'(bus.data_out), 64'd0);
        check_val("rst_keep_out", 64'(bus.keep_out), 64'd0);
        check_val("rst_err_keep", 64'(bus.err_keep), 64'd0);
        check_val("rst_ready_in", 64'(bus.ready_in), 64'd0);
        check_val("rst_ready_insert", 64'(bus.ready_insert), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // H=2, two full beats: flush beat needed
        pay_data[0] = 32'h11223344; pay_keep[0] = 4'b1111; pay_k[0] = 4;
        pay_data[1] = 32'h55667788; pay_keep[1] = 4'b1111; pay_k[1] = 4;
        send_packet(32'h1234AABB, 2, 2, 0);
        drain();

        // H=3, single byte last beat: fits exactly
        pay_data[0] = 32'h11000000; pay_keep[0] = 4'b1000; pay_k[0] = 1;
        send_packet(32'h99AABBCC, 3, 1, 0);
        drain();

        // H=0 passthrough under a toggling ready_out
        rdy_mode = 3;
        gen_payload(3);
        send_packet($urandom, 0, 3, 0);
        drain();

        // Clamped header count, last beat forces a flush
        rdy_mode = 1;
        gen_payload(2);
        pay_k[1] = 3; pay_keep[1] = keep_top(3);
        send_packet(32'hCAFEF00D, 7, 2, 0);
        drain();

        // Back-to-back packets with valid_insert held high
        hold_ins = 1;
        gen_payload(2);
        send_packet(32'h01020304, 1, 2, 0);
        hold_ins = 0;
        gen_payload(3);
        send_packet(32'h0A0B0C0D, 3, 3, 0);
        drain();
        check_val("err_keep_clean", 64'(bus.err_keep), 64'd0);

        // Non-contiguous keep on the last beat: popcount still drives the count
        pay_data[0] = 32'hDEADBEEF; pay_keep[0] = 4'b1111; pay_k[0] = 4;
        pay_data[1] = 32'h5A6B7C8D; pay_keep[1] = 4'b1010; pay_k[1] = 2;
        send_packet(32'h00000042, 1, 2, 0);
        drain();
        check_val("err_keep_set", 64'(bus.err_keep), 64'd1);

        // Reset in the middle of a packet with the output stalled
        rdy_mode = 2;
        @(posedge clk);
        #1;
        bus.data_insert     = 32'h0000BEEF;
        bus.byte_insert_cnt = CW'(2);
        bus.valid_insert    = 1'b1;
        @(posedge clk);
        #1;
        bus.valid_insert = 1'b0;
        bus.valid_in     = 1'b1;
        bus.data_in      = 32'h13579BDF;
        bus.keep_in      = 4'b1111;
        bus.last_in      = 1'b0;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        check_val("mid_valid_out", 64'(bus.valid_out), 64'd1);
        check_val("mid_ready_insert", 64'(bus.ready_insert), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid_out", 64'(bus.valid_out), 64'd0);
        check_val("arst_ready_insert", 64'(bus.ready_insert), 64'd1);
        check_val("arst_err_keep", 64'(bus.err_keep), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 1;
        gen_payload(2);
        send_packet(32'h00C0FFEE, 3, 2, 0);
        drain();

        // Randomized packets under random backpressure and input gaps
        rdy_mode = 0;
        for (int p = 0; p < 40; p++) begin
            int nb;
            nb = $urandom_range(1, 4);
            gen_payload(nb);
            send_packet($urandom, $urandom_range(0, (p % 8 == 0) ? 7 : N), nb, 1);
        end
        rdy_mode = 1;
        drain();
        check_val("err_keep_final", 64'(bus.err_keep), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
